// File: rtl/rf_pkg.sv
// Register-file shared definitions: geometry and the registered write-port bundle.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef logic [RF_AW-1:0] rf_addr_t;

  typedef struct packed {
    logic             en;
    rf_addr_t         addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);

  logic [2*N-1:0] req_rot;
  logic           found;
  int             sum;

  // Rotating a doubled copy puts the search origin at bit 0.
  always_comb begin
    req_rot = {req_i, req_i} >> ptr_i;
    found   = 1'b0;
    sum     = 0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = k + int'(ptr_i);
        if (sum >= N) sum = sum - N;
        idx_o = PW'(sum);
      end
    end
    grant_o = (enable_i && found) ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources through a
// round-robin grant and a single registered output stage.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 ctrl_freeze,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 ctrl_writeEnable,
  output logic [AW-1:0]        ctrl_writeReg,
  output logic [DW-1:0]        data_writeReg,
  output logic [RF_NREGS-1:0]  pending_mask,
  output logic [15:0]          drop_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  rf_wr_t          wr_q, wr_d;
  logic [15:0]     drop_q, drop_d;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            xfer;
  logic [AW-1:0]   sel_reg;
  logic [DW-1:0]   sel_data;

  // Grant depends only on valids, freeze and reset, never on reg/data.
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .enable_i (ctrl_reset & ~ctrl_freeze),
    .grant_o  (grant),
    .idx_o    (grant_idx)
  );

  assign req_ready = grant;
  assign xfer      = |(grant & req_valid);
  assign sel_reg   = req_reg[int'(grant_idx)*AW +: AW];
  assign sel_data  = req_data[int'(grant_idx)*DW +: DW];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    wr_d.en  = 1'b0;
    drop_d   = drop_q;
    if (xfer) begin
      rr_ptr_d  = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
      wr_d.addr = sel_reg;
      wr_d.data = sel_data;
      wr_d.en   = (sel_reg != '0);
      // Register 0 writes are swallowed but still counted.
      if (sel_reg == '0 && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      rr_ptr_q <= '0;
      wr_q     <= '0;
      drop_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      drop_q   <= drop_d;
    end
  end

  assign ctrl_writeEnable = wr_q.en;
  assign ctrl_writeReg    = wr_q.addr;
  assign data_writeReg    = wr_q.data;
  assign drop_count       = drop_q;
  assign pending_mask     = wr_q.en ? (RF_NREGS'(1) << wr_q.addr) : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle reference model plus
// directed scenarios with literal expectations against an attached register file.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic                clock = 1'b0;
  logic                ctrl_reset;
  logic                ctrl_freeze;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_reg;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                ctrl_writeEnable;
  logic [AW-1:0]       ctrl_writeReg;
  logic [DW-1:0]       data_writeReg;
  logic [31:0]         pending_mask;
  logic [15:0]         drop_count;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_freeze      (ctrl_freeze),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pending_mask     (pending_mask),
    .drop_count       (drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file attached to the write port; reset also blocks its write.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clock)
    if (ctrl_reset && ctrl_writeEnable && ctrl_writeReg != 0)
      rf[ctrl_writeReg] = data_writeReg;

  // Reference model: pointer, pending write and drop counter as plain integers.
  bit          m_live = 0;
  int          m_ptr;
  bit          m_en;
  int          m_addr;
  logic [31:0] m_data;
  int          m_drop;

  function automatic int m_pick();
    if (!ctrl_reset || ctrl_freeze) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    int g;
    if (!ctrl_reset) begin
      m_live = 1; m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_drop = 0;
    end else if (m_live) begin
      g = m_pick();
      if (g >= 0) begin
        m_ptr  = (g + 1) % NREQ;
        m_addr = int'(req_reg[g*AW +: AW]);
        m_data = req_data[g*DW +: DW];
        m_en   = (m_addr != 0);
        if (m_addr == 0 && m_drop < 65535) m_drop++;
      end else begin
        m_en = 0;
      end
    end
  end

  always @(negedge clock) begin
    int g;
    if (m_live) begin
      g = m_pick();
      chk("m_ready", req_ready, (g < 0) ? 0 : (64'd1 << g));
      chk("m_we",    ctrl_writeEnable, m_en);
      chk("m_reg",   ctrl_writeReg, m_addr);
      chk("m_data",  data_writeReg, m_data);
      chk("m_pend",  pending_mask, m_en ? (64'd1 << m_addr) : 0);
      chk("m_drop",  drop_count, m_drop);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*AW +: AW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  logic [2:0] exp_rr [6];
  logic [2:0] exp_alt [4];

  initial begin
    exp_rr  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_alt = '{3'b001, 3'b100, 3'b001, 3'b100};

    // Reset with every requester asserting
    ctrl_reset = 0; ctrl_freeze = 0; req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'h100 + i);
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_pend", pending_mask, 0);

    // Single source: requester 1 writes reg 5
    ctrl_reset = 1; req_valid = 0;
    tick();
    set_req(1, 5'd5, 32'hDEADBEEF); req_valid = 3'b010;
    #1 chk("single_ready", req_ready, 3'b010);
    tick();
    req_valid = 0;
    chk("single_we", ctrl_writeEnable, 1);
    chk("single_reg", ctrl_writeReg, 5);
    chk("single_data", data_writeReg, 32'hDEADBEEF);
    chk("single_pend", pending_mask, 32'h20);
    tick();
    chk("single_rf", rf[5], 32'hDEADBEEF);
    chk("single_idle_we", ctrl_writeEnable, 0);

    // Round-robin from pointer 0, all valid, no bubbles
    ctrl_reset = 0; tick(); ctrl_reset = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'(i));
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_all", req_ready, exp_rr[c]);
      tick();
      chk("rr_we", ctrl_writeEnable, 1);
    end
    req_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      #1 chk("rr_alt", req_ready, exp_alt[c]);
      tick();
    end
    req_valid = 0;
    tick();

    // Register 0 write is accepted and dropped
    set_req(2, 5'd0, 32'h1234); req_valid = 3'b100;
    #1 chk("r0_ready", req_ready, 3'b100);
    tick();
    req_valid = 0;
    chk("r0_we", ctrl_writeEnable, 0);
    chk("r0_drop", drop_count, 1);
    chk("r0_pend", pending_mask, 0);
    tick();
    chk("r0_rf", rf[0], 0);

    // Freeze with a write in flight
    set_req(0, 5'd9, 32'h99); req_valid = 3'b001;
    tick();
    ctrl_freeze = 1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("frz_ready", req_ready, 0);
      if (c == 0) chk("frz_inflight_we", ctrl_writeEnable, 1);
      tick();
    end
    chk("frz_rf", rf[9], 32'h99);
    ctrl_freeze = 0;
    #1 chk("frz_release", req_ready, 3'b001);
    tick();
    req_valid = 0;
    tick();

    // Collision on reg 7 from pointer 1: requester 1 first, requester 0 last
    set_req(0, 5'd7, 32'hA); set_req(1, 5'd7, 32'hB); req_valid = 3'b011;
    #1 chk("col_first", req_ready, 3'b010);
    tick();
    req_valid = 3'b001;
    #1 chk("col_second", req_ready, 3'b001);
    tick();
    req_valid = 0;
    tick(); tick();
    chk("col_rf", rf[7], 32'hA);

    // Reset right after a grant discards that write
    set_req(1, 5'd3, 32'h33); req_valid = 3'b010;
    #1 chk("rstw_ready", req_ready, 3'b010);
    tick();
    req_valid = 0; ctrl_reset = 0;
    tick();
    chk("rstw_we", ctrl_writeEnable, 0);
    ctrl_reset = 1;
    tick(); tick();
    chk("rstw_rf", rf[3], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
